// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// instruction-class bit positions and the encodings of the mux selects and
// fault codes driven towards the datapath.
package ctrl_pkg;

    // Opcode field values, ins[OP_LO+5:OP_LO]
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADD  = 6'b100000;
    localparam logic [5:0] OP_NOR  = 6'b100110;
    localparam logic [5:0] OP_NORI = 6'b001110;
    localparam logic [5:0] OP_NOT  = 6'b000100;
    localparam logic [5:0] OP_ROLV = 6'b000000;
    localparam logic [5:0] OP_RORV = 6'b000010;
    localparam logic [5:0] OP_BLEU = 6'b010000;
    localparam logic [5:0] OP_JR   = 6'b001000;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    // Bit positions inside the one-hot instruction-class vector
    localparam int CLS_W    = 11;
    localparam int CLS_LW   = 0;
    localparam int CLS_SW   = 1;
    localparam int CLS_ADD  = 2;
    localparam int CLS_NOR  = 3;
    localparam int CLS_NORI = 4;
    localparam int CLS_NOT  = 5;
    localparam int CLS_ROLV = 6;
    localparam int CLS_RORV = 7;
    localparam int CLS_BLEU = 8;
    localparam int CLS_JR   = 9;
    localparam int CLS_JAL  = 10;

    // Controller states, one per clock
    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        JUMP   = 3'd5,
        FAULT  = 3'd6
    } state_t;

    // PC source select
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_REG    = 2'b11;

    // Register-file destination select
    localparam logic [1:0] REG_DST_RT  = 2'b00;
    localparam logic [1:0] REG_DST_RD  = 2'b01;
    localparam logic [1:0] REG_DST_R31 = 2'b10;

    // Register-file write-data select
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    // Fault codes
    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_ILLEGAL = 2'b01;
    localparam logic [1:0] FC_IMEM    = 2'b10;
    localparam logic [1:0] FC_DMEM    = 2'b11;

endpackage

// File: rtl/control_decode.sv
// Opcode classifier: turns the latched 6-bit opcode into a one-hot
// instruction-class vector; an opcode matching no class is illegal.
module control_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]       opcode,
    output logic [CLS_W-1:0] cls,
    output logic             illegal
);

    // One class bit per recognised opcode, nothing set for unknown ones
    always_comb begin
        cls = '0;
        case (opcode)
            OP_LW:   cls[CLS_LW]   = 1'b1;
            OP_SW:   cls[CLS_SW]   = 1'b1;
            OP_ADD:  cls[CLS_ADD]  = 1'b1;
            OP_NOR:  cls[CLS_NOR]  = 1'b1;
            OP_NORI: cls[CLS_NORI] = 1'b1;
            OP_NOT:  cls[CLS_NOT]  = 1'b1;
            OP_ROLV: cls[CLS_ROLV] = 1'b1;
            OP_RORV: cls[CLS_RORV] = 1'b1;
            OP_BLEU: cls[CLS_BLEU] = 1'b1;
            OP_JR:   cls[CLS_JR]   = 1'b1;
            OP_JAL:  cls[CLS_JAL]  = 1'b1;
            default: cls = '0;
        endcase
        illegal = (cls == '0);
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: latches the fetched opcode and walks it through
// FETCH/DECODE/EXEC/MEM/WB (or JUMP), driving the datapath strobes, watching
// the memory handshakes for timeouts and counting retired instructions.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int INS_W   = 32,
    parameter int OP_LO   = 26,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [INS_W-1:0] ins,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             br_cond,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src,
    output logic [4:0]       alu_ctrl,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired
);

    localparam int              WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [5:0]         op_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [1:0]         code_q;
    logic [1:0]         code_nxt;
    logic [CNT_W-1:0]   retired_q;
    logic               retire;
    logic [CLS_W-1:0]   cls;
    logic               illegal;
    logic               alu_only;
    logic               writes_rd;
    logic               ins_unused;

    // Only the opcode field matters here; the rest goes to the datapath
    assign ins_unused = ^ins;

    control_decode u_decode (
        .opcode  (op_q),
        .cls     (cls),
        .illegal (illegal)
    );

    assign alu_only  = cls[CLS_ADD] | cls[CLS_NOR] | cls[CLS_NORI] |
                       cls[CLS_NOT] | cls[CLS_ROLV] | cls[CLS_RORV];
    assign writes_rd = cls[CLS_ADD] | cls[CLS_NOR] | cls[CLS_ROLV] | cls[CLS_RORV];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_nxt;
    end

    // Opcode latch, loaded when the fetch handshake completes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          op_q <= '0;
        else if (state == FETCH && imem_ready) op_q <= ins[OP_LO+5:OP_LO];
    end

    // Handshake wait counter: restarts on every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                              wait_cnt <= '0;
        else if (state_nxt != state)               wait_cnt <= '0;
        else if (state == FETCH || state == MEM)   wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    // Fault code register, written only on the transition into FAULT
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) code_q <= FC_NONE;
        else          code_q <= code_nxt;
    end

    // Retired-instruction counter, bumped as the retiring state is left
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    retired_q <= '0;
        else if (retire) retired_q <= retired_q + CNT_W'(1);
    end

    // Next-state, fault-code and retire decision; ready always beats timeout
    always_comb begin
        state_nxt = state;
        code_nxt  = code_q;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                if (imem_ready) begin
                    state_nxt = DECODE;
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nxt = FAULT;
                    code_nxt  = FC_IMEM;
                end
            end
            DECODE: begin
                if (illegal) begin
                    state_nxt = FAULT;
                    code_nxt  = FC_ILLEGAL;
                end else if (cls[CLS_JR] || cls[CLS_JAL]) begin
                    state_nxt = JUMP;
                end else begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (cls[CLS_BLEU]) begin
                    retire    = 1'b1;
                    state_nxt = FETCH;
                end else if (cls[CLS_LW] || cls[CLS_SW]) begin
                    state_nxt = MEM;
                end else if (alu_only) begin
                    state_nxt = WB;
                end
            end
            MEM: begin
                if (dmem_ready) begin
                    if (cls[CLS_SW]) begin
                        retire    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = WB;
                    end
                end else if (wait_cnt == LAST_WAIT) begin
                    state_nxt = FAULT;
                    code_nxt  = FC_DMEM;
                end
            end
            WB: begin
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            JUMP: begin
                retire    = 1'b1;
                state_nxt = FETCH;
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // Datapath strobes from state and latched opcode, forced low during reset
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = REG_DST_RT;
        mem_to_reg = MTR_ALU;
        alu_src    = 1'b0;
        if (reset_n) begin
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_SEQ;
                    end
                end
                EXEC: begin
                    alu_src = cls[CLS_LW] | cls[CLS_SW] | cls[CLS_NORI] | cls[CLS_BLEU];
                    if (cls[CLS_BLEU]) begin
                        pc_write = br_cond;
                        pc_src   = PC_SRC_BRANCH;
                    end
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = cls[CLS_SW];
                end
                WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = writes_rd ? REG_DST_RD : REG_DST_RT;
                    mem_to_reg = cls[CLS_LW] ? MTR_MEM : MTR_ALU;
                end
                JUMP: begin
                    pc_write = 1'b1;
                    if (cls[CLS_JAL]) begin
                        pc_src     = PC_SRC_JUMP;
                        reg_write  = 1'b1;
                        reg_dst    = REG_DST_R31;
                        mem_to_reg = MTR_PC4;
                    end else begin
                        pc_src = PC_SRC_REG;
                    end
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

    assign alu_ctrl   = op_q[5:1];
    assign fault      = (state == FAULT);
    assign fault_code = code_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a per-instruction reference model
// lists the expected outputs of every cycle, the driver pushes them as it
// drives the inputs, and a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 16;

    // Instruction kinds as seen by the reference model
    localparam int K_ILL = -1;
    localparam int K_ALU = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_BR  = 3;
    localparam int K_JR  = 4;
    localparam int K_JAL = 5;

    typedef struct packed {
        logic             imem_req;
        logic             ir_write;
        logic             pc_write;
        logic [1:0]       pc_src;
        logic             dmem_req;
        logic             dmem_we;
        logic             reg_write;
        logic [1:0]       reg_dst;
        logic [1:0]       mem_to_reg;
        logic             alu_src;
        logic [4:0]       alu_ctrl;
        logic             fault;
        logic [1:0]       fault_code;
        logic [CNT_W-1:0] retired;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [31:0]      ins;
    logic             imem_ready;
    logic             dmem_ready;
    logic             br_cond;
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             dmem_req;
    logic             dmem_we;
    logic             reg_write;
    logic [1:0]       reg_dst;
    logic [1:0]       mem_to_reg;
    logic             alu_src;
    logic [4:0]       alu_ctrl;
    logic             fault;
    logic [1:0]       fault_code;
    logic [CNT_W-1:0] retired;

    exp_t dutOut;
    exp_t sb[$];
    exp_t monExp;
    int   compared   = 0;
    int   mismatched = 0;
    int   cycleTag   = 0;
    bit   skipWait   = 1'b0;

    // Reference model state
    logic [5:0] mLastOp  = 6'd0;
    int         mRetired = 0;
    logic       mFault   = 1'b0;
    logic [1:0] mCode    = 2'b00;

    logic [5:0] legalOps [11] = '{6'b100011, 6'b101011, 6'b100000, 6'b100110,
                                  6'b001110, 6'b000100, 6'b000000, 6'b000010,
                                  6'b010000, 6'b001000, 6'b000011};

    multicycle_control #(
        .INS_W   (32),
        .OP_LO   (26),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ins        (ins),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .br_cond    (br_cond),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_ctrl   (alu_ctrl),
        .fault      (fault),
        .fault_code (fault_code),
        .retired    (retired)
    );

    assign dutOut = {imem_req, ir_write, pc_write, pc_src, dmem_req, dmem_we,
                     reg_write, reg_dst, mem_to_reg, alu_src, alu_ctrl,
                     fault, fault_code, retired};

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int tag, input exp_t got, input exp_t exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s #%0d: got %h required %h (got retired=%0d fault=%b code=%b, required retired=%0d fault=%b code=%b)",
                     name, tag, got, exp, got.retired, got.fault, got.fault_code,
                     exp.retired, exp.fault, exp.fault_code);
        end
    endtask

    // Monitor: every cycle that has a pushed expectation is compared mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            monExp = sb.pop_front();
            cycleTag++;
            checkOutput("cycle", cycleTag, dutOut, monExp);
        end
    end

    function automatic int kindOf(input logic [5:0] op);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b010000: return K_BR;
            6'b001000: return K_JR;
            6'b000011: return K_JAL;
            6'b100000, 6'b100110, 6'b001110,
            6'b000100, 6'b000000, 6'b000010: return K_ALU;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic logic usesImm(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b001110) || (op == 6'b010000);
    endfunction

    function automatic logic writesRd(input logic [5:0] op);
        return (op == 6'b100000) || (op == 6'b100110) || (op == 6'b000000) || (op == 6'b000010);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Idle outputs for the current model state
    function automatic exp_t blank();
        exp_t e;
        e            = '0;
        e.alu_ctrl   = mLastOp[5:1];
        e.retired    = CNT_W'(mRetired);
        e.fault      = mFault;
        e.fault_code = mCode;
        return e;
    endfunction

    task automatic emit(input logic ir, input logic dr, input logic bc, input exp_t e);
        if (!skipWait) begin
            @(posedge clk);
            #1;
        end
        skipWait   = 1'b0;
        imem_ready = ir;
        dmem_ready = dr;
        br_cond    = bc;
        sb.push_back(e);
    endtask

    task automatic emitFault(input int n, input logic [1:0] code);
        mFault = 1'b1;
        mCode  = code;
        for (int i = 0; i < n; i++) emit(1'b1, rb(), rb(), blank());
    endtask

    task automatic assertReset();
        reset_n = 1'b0;
        #1;
        mLastOp  = 6'd0;
        mRetired = 0;
        mFault   = 1'b0;
        mCode    = 2'b00;
        checkOutput("reset", 0, dutOut, blank());
    endtask

    task automatic releaseReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        skipWait = 1'b1;
    endtask

    // One instruction through the reference model; abortMem stops after one MEM wait
    task automatic applyStimulus(input logic [5:0] op, input int iDly, input int dDly,
                                 input logic br, input bit abortMem);
        exp_t e;
        int   k;
        ins = {op, 26'($urandom)};
        k   = kindOf(op);
        for (int i = 0; i < iDly && i < TIMEOUT; i++) begin
            e = blank();
            e.imem_req = 1'b1;
            emit(1'b0, rb(), rb(), e);
        end
        if (iDly >= TIMEOUT) begin
            emitFault(3, 2'b10);
            return;
        end
        e = blank();
        e.imem_req = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        emit(1'b1, rb(), rb(), e);
        mLastOp = op;
        emit(rb(), rb(), rb(), blank());
        if (k == K_ILL) begin
            emitFault(3, 2'b01);
            return;
        end
        if (k == K_JR || k == K_JAL) begin
            e = blank();
            e.pc_write = 1'b1;
            if (k == K_JAL) begin
                e.pc_src     = 2'b10;
                e.reg_write  = 1'b1;
                e.reg_dst    = 2'b10;
                e.mem_to_reg = 2'b10;
            end else begin
                e.pc_src = 2'b11;
            end
            emit(rb(), rb(), rb(), e);
            mRetired++;
            return;
        end
        e = blank();
        e.alu_src = usesImm(op);
        if (k == K_BR) begin
            e.pc_write = br;
            e.pc_src   = 2'b01;
        end
        emit(rb(), rb(), br, e);
        if (k == K_BR) begin
            mRetired++;
            return;
        end
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < dDly && i < TIMEOUT; i++) begin
                e = blank();
                e.dmem_req = 1'b1;
                e.dmem_we  = (k == K_SW);
                emit(rb(), 1'b0, rb(), e);
                if (abortMem) return;
            end
            if (dDly >= TIMEOUT) begin
                emitFault(3, 2'b11);
                return;
            end
            e = blank();
            e.dmem_req = 1'b1;
            e.dmem_we  = (k == K_SW);
            emit(rb(), 1'b1, rb(), e);
            if (k == K_SW) begin
                mRetired++;
                return;
            end
        end
        e = blank();
        e.reg_write  = 1'b1;
        e.reg_dst    = writesRd(op) ? 2'b01 : 2'b00;
        e.mem_to_reg = (k == K_LW) ? 2'b01 : 2'b00;
        emit(rb(), rb(), rb(), e);
        mRetired++;
    endtask

    initial begin
        int iDly;
        int dDly;
        reset_n    = 1'b0;
        ins        = '0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        br_cond    = 1'b0;
        #2;
        assertReset();
        releaseReset();

        // Directed instructions with immediate handshakes
        applyStimulus(6'b100000, 0, 0, 1'b0, 1'b0);
        applyStimulus(6'b100011, 0, 3, 1'b0, 1'b0);
        applyStimulus(6'b010000, 0, 0, 1'b1, 1'b0);
        applyStimulus(6'b010000, 0, 0, 1'b0, 1'b0);
        applyStimulus(6'b000011, 0, 0, 1'b0, 1'b0);
        applyStimulus(6'b001000, 0, 0, 1'b0, 1'b0);
        applyStimulus(6'b101011, 1, 2, 1'b0, 1'b0);
        applyStimulus(6'b001110, 2, 0, 1'b0, 1'b0);

        // Ready arriving on the last permitted wait cycle still succeeds
        applyStimulus(6'b100011, TIMEOUT - 1, TIMEOUT - 1, 1'b0, 1'b0);

        // Randomised instruction stream
        for (int n = 0; n < 40; n++) begin
            iDly = ($urandom_range(0, 7) == 0) ? $urandom_range(3, TIMEOUT - 1) : $urandom_range(0, 2);
            dDly = ($urandom_range(0, 7) == 0) ? $urandom_range(3, TIMEOUT - 1) : $urandom_range(0, 2);
            applyStimulus(legalOps[$urandom_range(0, 10)], iDly, dDly, rb(), 1'b0);
        end

        // Reset in the middle of a store's memory phase
        applyStimulus(6'b101011, 0, 5, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        assertReset();
        releaseReset();
        applyStimulus(6'b100110, 0, 0, 1'b0, 1'b0);

        // Illegal opcode
        applyStimulus(6'b111111, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        assertReset();
        releaseReset();

        // Instruction memory timeout
        applyStimulus(6'b100000, 0, 0, 1'b0, 1'b0);
        applyStimulus(6'b000100, TIMEOUT, 0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        assertReset();
        releaseReset();

        // Data memory timeout
        applyStimulus(6'b100011, 0, TIMEOUT, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        assertReset();
        releaseReset();
        applyStimulus(6'b000010, 0, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control unit for the 6-bit-opcode core.
- Latches each fetched instruction and sequences it through FETCH/DECODE/EXEC/MEM/WB, one state per clock.
- Drives every datapath control strobe, including real branch/jump PC control, plus memory handshakes with timeout fault detection and a retired-instruction counter.
- Sits between the instruction/data memory ports and the datapath (PC, register file, ALU).

Parameters:
INS_W, 32, instruction word width
OP_LO, 26, LSB of opcode field; opcode = ins[OP_LO+5:OP_LO]
TIMEOUT, 15, max wait cycles for imem_ready/dmem_ready before fault
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
ins  in  INS_W  instruction word from imem, valid when imem_ready=1
imem_ready  in  1  imem data valid / request accepted
dmem_ready  in  1  dmem access complete
br_cond  in  1  ALU unsigned a<=b result for bleu, valid in EXEC
imem_req  out  1  instruction fetch request
ir_write  out  1  load instruction register
pc_write  out  1  update PC
pc_src  out  2  00 pc+4, 01 branch target, 10 jump target (jal), 11 register (jr)
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (with dmem_req)
reg_write  out  1  register file write enable
reg_dst  out  2  00 rt, 01 rd, 10 r31
mem_to_reg  out  2  00 ALU, 01 memory, 10 pc+4
alu_src  out  1  1 = immediate operand
alu_ctrl  out  5  opcode[5:1] of latched instruction
fault  out  1  sticky fault flag
fault_code  out  2  01 illegal opcode, 10 imem timeout, 11 dmem timeout
retired  out  CNT_W  count of completed instructions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, reset_n=0): state=FETCH, internal opcode register=0, wait counter=0, retired=0, fault=0, fault_code=00; all strobes 0, pc_src/reg_dst/mem_to_reg=00, alu_ctrl=0.
- Reset asserted mid-instruction aborts it; no partial writes are retired.
- Opcodes: lw 100011, sw 101011, add 100000, nor 100110, nori 001110, not 000100, rolv 000000, rorv 000010, bleu 010000, jr 001000, jal 000011. Any other value is illegal.
- All strobes are Moore outputs, decoded from state plus the latched opcode.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_write=1, pc_write=1, pc_src=00, latch opcode, go to DECODE.
  - Otherwise increment the wait counter; when it reaches TIMEOUT, go to FAULT with code 10.
- DECODE:
  - Illegal opcode -> FAULT, code 01.
  - jr/jal -> JUMP.
  - Everything else -> EXEC.
- EXEC:
  - alu_src=1 for lw, sw, nori, bleu.
  - bleu: pc_write=br_cond, pc_src=01; retire; go to FETCH.
  - lw/sw -> MEM. Others -> WB.
- MEM:
  - dmem_req=1; dmem_we=1 for sw.
  - On dmem_ready: sw retires and goes to FETCH; lw goes to WB.
  - Timeout at TIMEOUT cycles -> FAULT, code 11.
- WB:
  - reg_write=1.
  - reg_dst: 00 for lw, nori, not; 01 for add, nor, rolv, rorv.
  - mem_to_reg: 01 for lw, else 00.
  - Retire; go to FETCH.
- JUMP:
  - pc_write=1; pc_src=11 for jr, 10 for jal.
  - jal also: reg_write=1, reg_dst=10, mem_to_reg=10.
  - Retire; go to FETCH.
- FAULT:
  - All strobes 0; fault=1; fault_code held.
  - Terminal until reset.
- Wait counter clears on every state change. A ready arriving in the same cycle the counter reaches TIMEOUT counts as success (ready wins).
- retired increments by 1 on the clock edge that leaves the retiring state.
- Latencies (ready=1 immediately): bleu/jr/jal 3 cycles; R-type/imm ALU 4; sw 4; lw 5.

Decomposition:
- Package ctrl_pkg:
  - opcode localparams;
  - state enum {FETCH, DECODE, EXEC, MEM, WB, JUMP, FAULT};
  - pc_src/reg_dst/mem_to_reg encodings;
  - fault_code encodings.
- Sub-module control_decode: combinational opcode -> instruction-class one-hots plus illegal flag.
- FSM, wait counter and retired counter live in the top.

Test Plan:
- add (ins[31:26]=100000), imem_ready/dmem_ready tied 1 -> reg_write=1 with reg_dst=01 on cycle 4; retired 0->1; alu_ctrl=10000.
- lw with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0; WB has mem_to_reg=01, reg_dst=00; total 8 cycles.
- bleu with br_cond=1, then bleu with br_cond=0 -> EXEC pc_write=1 pc_src=01, then pc_write=0; each takes 3 cycles and retires.
- jal -> JUMP cycle shows pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10. jr -> pc_src=11, reg_write=0.
- opcode 111111 -> FAULT after DECODE, fault_code=01, no further imem_req. imem_ready held 0 with TIMEOUT=15 -> fault_code=10 after 15 waiting cycles.
- reset_n pulsed low during MEM of sw -> outputs return to reset values immediately, retired=0, FETCH resumes with imem_req=1.
